// File: rtl/flag_branch_eval.sv
// flag_branch_eval: architectural NZCV flag register with same-cycle
// forwarding, branch resolve (B.cond/CBZ/CBNZ/B), taken counter.
// Ports: clk, rst (async active-low); EX side ex_valid, set_flags,
//   alu_flags{N,Z,C,V}; branch side br_valid, br_type, cond, reg_zero;
//   control stall, flush; outputs flags, br_done, br_taken, taken_cnt.
module flag_branch_eval #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             set_flags,
  input  logic [3:0]       alu_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  input  logic             reg_zero,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags,
  output logic             br_done,
  output logic             br_taken,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] BT_COND = 2'b00;
  localparam logic [1:0] BT_CBZ  = 2'b01;
  localparam logic [1:0] BT_CBNZ = 2'b10;
  localparam logic [1:0] BT_B    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] eff;
  logic       fn, fz, fc, fv;
  logic       flag_wr;
  logic       hi, ge, gt;
  logic       cond_ok;
  logic       decision;
  logic       accept;

  // Forward the EX flag result so a branch in the same cycle sees it.
  assign flag_wr = ex_valid & set_flags;
  assign eff     = flag_wr ? alu_flags : flags;

  assign fn = eff[3];
  assign fz = eff[2];
  assign fc = eff[1];
  assign fv = eff[0];

  assign hi = fc & ~fz;
  assign ge = (fn == fv);
  assign gt = ~fz & ge;

  always_comb begin
    cond_ok = 1'b1;
    unique case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = ~fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = ~fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = ~fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = ~fv;
      4'b1000: cond_ok = hi;
      4'b1001: cond_ok = ~hi;
      4'b1010: cond_ok = ge;
      4'b1011: cond_ok = ~ge;
      4'b1100: cond_ok = gt;
      4'b1101: cond_ok = ~gt;
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    decision = 1'b1;
    unique case (br_type)
      BT_COND: decision = cond_ok;
      BT_CBZ:  decision = reg_zero;
      BT_CBNZ: decision = ~reg_zero;
      BT_B:    decision = 1'b1;
      default: decision = 1'b1;
    endcase
  end

  // Flush drops the branch even while stalled.
  assign accept = br_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags     <= 4'b0000;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      taken_cnt <= '0;
    end else begin
      if (flag_wr && !stall)
        flags <= alu_flags;
      br_done  <= accept;
      br_taken <= accept & decision;
      if (accept && decision && taken_cnt != CNT_MAX)
        taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule
